// File: rtl/scan_mux_reg_if.sv
// Bus bundle for scan_mux_reg: channel data, select control, strobe and
// the registered outputs. The master drives the controls, the slave (the
// selector) drives the outputs.
interface scan_mux_reg_if #(
   parameter int WIDTH = 1,
   parameter int N_IN  = 8
);
   localparam int SEL_W = $clog2(N_IN);

   logic [N_IN*WIDTH-1:0] data_in;
   logic [SEL_W-1:0]      sel_in;
   logic                  sel_load;
   logic                  scan_en;
   logic                  strobe_n;
   logic [WIDTH-1:0]      y;
   logic [WIDTH-1:0]      y_n;
   logic [SEL_W-1:0]      y_sel;
   logic                  y_valid;
   logic [SEL_W-1:0]      cur_sel;
   logic                  wrap;
   logic                  sel_err;

   modport master (
      output data_in, sel_in, sel_load, scan_en, strobe_n,
      input  y, y_n, y_sel, y_valid, cur_sel, wrap, sel_err
   );

   modport slave (
      input  data_in, sel_in, sel_load, scan_en, strobe_n,
      output y, y_n, y_sel, y_valid, cur_sel, wrap, sel_err
   );
endinterface

// File: rtl/scan_mux_reg.sv
// Registered N-to-1 selector with a latched select register and an
// auto-scan mode that steps through the channels every SCAN_DIV cycles.
// The output register holds the selected channel, its select index and a
// valid flag; y_n is simply the inverse of the y register.
module scan_mux_reg #(
   parameter int WIDTH    = 1,
   parameter int N_IN     = 8,
   parameter int SCAN_DIV = 4
) (
   input logic           clk,
   input logic           rst_n,
   scan_mux_reg_if.slave bus
);
   localparam int SEL_W = $clog2(N_IN);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);
   localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(N_IN);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [SEL_W-1:0] sel_q;
   logic [DIV_W-1:0] div_cnt;
   logic             wrap_q;
   logic             err_q;
   logic [WIDTH-1:0] y_q;
   logic [SEL_W-1:0] y_sel_q;
   logic             y_valid_q;
   logic             load_ok;

   logic [WIDTH-1:0] chan [N_IN];

   for (genvar k = 0; k < N_IN; k++) begin : g_chan
      assign chan[k] = bus.data_in[k*WIDTH +: WIDTH];
   end

   // Loads are only honoured for indices that address a real channel.
   assign load_ok = bus.sel_load && ({1'b0, bus.sel_in} < SEL_LIM);

   // Select register and scan divider; an accepted load beats a scan step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= '0;
         div_cnt <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         if (load_ok) begin
            sel_q   <= bus.sel_in;
            div_cnt <= '0;
         end else begin
            if (bus.sel_load) begin
               err_q <= 1'b1;
            end
            if (bus.scan_en) begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (sel_q == SEL_LAST) begin
                     sel_q  <= '0;
                     wrap_q <= 1'b1;
                  end else begin
                     sel_q <= sel_q + SEL_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end else begin
               div_cnt <= '0;
            end
         end
      end
   end

   // Output register: sample the channel addressed by the pre-edge select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q       <= '0;
         y_sel_q   <= '0;
         y_valid_q <= 1'b0;
      end else begin
         y_q       <= bus.strobe_n ? '0 : chan[sel_q];
         y_sel_q   <= sel_q;
         y_valid_q <= ~bus.strobe_n;
      end
   end

   assign bus.y       = y_q;
   assign bus.y_n     = ~y_q;
   assign bus.y_sel   = y_sel_q;
   assign bus.y_valid = y_valid_q;
   assign bus.cur_sel = sel_q;
   assign bus.wrap    = wrap_q;
   assign bus.sel_err = err_q;
endmodule

// File: tb/tb_scan_mux_reg.sv
// Directed bench for scan_mux_reg: an 8-channel 4-bit instance with
// SCAN_DIV=4 and a 6-channel 4-bit instance with SCAN_DIV=1.
module tb_scan_mux_reg;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   scan_mux_reg_if #(.WIDTH(4), .N_IN(8)) bus_a ();
   scan_mux_reg_if #(.WIDTH(4), .N_IN(6)) bus_b ();

   scan_mux_reg #(.WIDTH(4), .N_IN(8), .SCAN_DIV(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   scan_mux_reg #(.WIDTH(4), .N_IN(6), .SCAN_DIV(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_sel;
      int prev_sel;
      int wrap_cnt;

      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      for (int k = 0; k < 8; k++) bus_a.data_in[k*4 +: 4] = 4'(k + 5);
      for (int k = 0; k < 6; k++) bus_b.data_in[k*4 +: 4] = 4'(k + 9);
      bus_a.sel_in = '0; bus_a.sel_load = 1'b0; bus_a.scan_en = 1'b0; bus_a.strobe_n = 1'b0;
      bus_b.sel_in = '0; bus_b.sel_load = 1'b0; bus_b.scan_en = 1'b0; bus_b.strobe_n = 1'b0;

      tick(); tick();
      check("rst_y",       bus_a.y, 0);
      check("rst_y_n",     bus_a.y_n, 4'hF);
      check("rst_y_sel",   bus_a.y_sel, 0);
      check("rst_y_valid", bus_a.y_valid, 0);
      check("rst_cur_sel", bus_a.cur_sel, 0);
      check("rst_wrap",    bus_a.wrap, 0);
      check("rst_sel_err", bus_a.sel_err, 0);

      rst_n = 1'b1;
      tick();
      check("post_rst_y", bus_a.y, 5);
      check("post_rst_valid", bus_a.y_valid, 1);

      // Manual load of channel 3
      bus_a.sel_in = 3'd3; bus_a.sel_load = 1'b1;
      tick();
      check("man_cur_sel", bus_a.cur_sel, 3);
      check("man_y_lat", bus_a.y, 5);
      bus_a.sel_load = 1'b0;
      tick();
      check("man_y", bus_a.y, 8);
      check("man_y_n", bus_a.y_n, 7);
      check("man_y_sel", bus_a.y_sel, 3);
      check("man_y_valid", bus_a.y_valid, 1);

      // Strobe held high for two cycles
      bus_a.strobe_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("stb_y", bus_a.y, 0);
         check("stb_y_n", bus_a.y_n, 4'hF);
         check("stb_valid", bus_a.y_valid, 0);
      end
      bus_a.strobe_n = 1'b0;
      tick();
      check("stb_rec_y", bus_a.y, 8);
      check("stb_rec_valid", bus_a.y_valid, 1);

      // Scan from channel 0 over one full rotation
      bus_a.sel_in = 3'd0; bus_a.sel_load = 1'b1;
      tick();
      check("scan_start_sel", bus_a.cur_sel, 0);
      bus_a.sel_load = 1'b0;
      bus_a.scan_en  = 1'b1;
      prev_sel = 0;
      wrap_cnt = 0;
      for (int i = 1; i <= 32; i++) begin
         tick();
         exp_sel = (i / 4) % 8;
         check("scan_sel", bus_a.cur_sel, exp_sel);
         check("scan_wrap", bus_a.wrap, (i == 32) ? 1 : 0);
         check("scan_y", bus_a.y, prev_sel + 5);
         check("scan_y_sel", bus_a.y_sel, prev_sel);
         if (bus_a.wrap) wrap_cnt++;
         prev_sel = exp_sel;
      end
      check("scan_wrap_count", wrap_cnt, 1);

      // Load colliding with the 7->0 step
      for (int i = 0; i < 31; i++) tick();
      check("col_pre_sel", bus_a.cur_sel, 7);
      bus_a.sel_in = 3'd2; bus_a.sel_load = 1'b1;
      tick();
      check("col_sel", bus_a.cur_sel, 2);
      check("col_wrap", bus_a.wrap, 0);
      bus_a.sel_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("col_hold", bus_a.cur_sel, 2);
      end
      tick();
      check("col_next_step", bus_a.cur_sel, 3);

      // Leaving scan mode holds the select
      bus_a.scan_en = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("man_hold_sel", bus_a.cur_sel, 3);

      // Six-channel instance: out-of-range load, then scan every cycle
      bus_b.sel_in = 3'd7; bus_b.sel_load = 1'b1;
      tick();
      check("rng_err", bus_b.sel_err, 1);
      check("rng_sel_kept", bus_b.cur_sel, 0);
      bus_b.sel_load = 1'b0;
      tick();
      check("rng_err_pulse", bus_b.sel_err, 0);
      bus_b.sel_in = 3'd4; bus_b.sel_load = 1'b1;
      tick();
      check("rng_load_sel", bus_b.cur_sel, 4);
      check("rng_load_err", bus_b.sel_err, 0);
      bus_b.sel_load = 1'b0;
      bus_b.scan_en  = 1'b1;
      prev_sel = 4;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_sel = (4 + i) % 6;
         check("rng_scan_sel", bus_b.cur_sel, exp_sel);
         check("rng_scan_wrap", bus_b.wrap, (exp_sel == 0) ? 1 : 0);
         check("rng_scan_y", bus_b.y, prev_sel + 9);
         prev_sel = exp_sel;
      end
      bus_b.scan_en = 1'b0;

      // Asynchronous reset in the middle of a scan
      bus_a.scan_en = 1'b1;
      tick(); tick();
      check("ar_pre_y", bus_a.y, 8);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_y", bus_a.y, 0);
      check("ar_y_n", bus_a.y_n, 4'hF);
      check("ar_valid", bus_a.y_valid, 0);
      check("ar_cur_sel", bus_a.cur_sel, 0);
      check("ar_y_sel", bus_a.y_sel, 0);
      tick(); tick();
      check("ar_held_y", bus_a.y, 0);
      check("ar_held_sel", bus_a.cur_sel, 0);
      rst_n = 1'b1;
      tick();
      check("ar_rel_y", bus_a.y, 5);
      check("ar_rel_valid", bus_a.y_valid, 1);
      check("ar_rel_y_sel", bus_a.y_sel, 0);
      tick(); tick(); tick();
      check("ar_first_step", bus_a.cur_sel, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
